// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register carrying a control bundle and a payload, with flush.
// SKID=1 selects a 2-entry skid buffer with registered in_ready; macro PIPE_STAGE_STATS_EN adds stall/bubble counters.
module pipe_stage_reg #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 133,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  // Handshake: a beat moves on a rising edge when valid and ready are both high
  // on that side; valid never depends on ready, and a presented beat holds
  // stable until it is taken (or killed by flush/reset).

  // The encoding equals the beat count, so occupancy doubles as the state probe.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;
  logic              drain;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = out_valid ? head_ctrl_q : '0;
  assign out_data  = head_data_q;
  assign occupancy = 2'(state_q);

  // Without a skid entry the stage can only take a beat when the head leaves.
  assign in_ready = (SKID != 0) ? in_ready_q : (out_ready | ~out_valid);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_ctrl_d = in_ctrl;
          head_data_d = in_data;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          head_ctrl_d = in_ctrl;
          head_data_d = in_data;
        end else if (accept && (SKID != 0)) begin
          // Head is stalled: the younger beat parks in the skid entry.
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
          state_d     = ST_TWO;
        end else if (drain) begin
          head_ctrl_d = '0;
          state_d     = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          head_ctrl_d = skid_ctrl_q;
          head_data_d = skid_data_q;
          skid_ctrl_d = '0;
          state_d     = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush kills everything, including a beat accepted this cycle; payloads stay stale.
    if (flush) begin
      state_d     = ST_EMPTY;
      head_ctrl_d = '0;
      head_data_d = head_data_q;
      skid_ctrl_d = '0;
      skid_data_d = skid_data_q;
    end

    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush deliberately leaves them alone.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (!out_valid && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, table vectors,
// hand sequences for multi-cycle corners, and a scoreboard on every drain.
module tb_pipe_stage_reg;
  localparam int CTRL_W = 11;
  localparam int DATA_W = 133;
  localparam int BW     = CTRL_W + DATA_W;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  logic              in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;

  logic              in_valid0, in_ready0, out_valid0, out_ready0;
  logic [CTRL_W-1:0] in_ctrl0, out_ctrl0;
  logic [DATA_W-1:0] in_data0, out_data0;
  logic [1:0]        occupancy0;

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt, bubble_cnt, stall_cnt0, bubble_cnt0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] exp0_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occupancy0)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
`endif
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_take(input string name, input logic [BW-1:0] act, inout logic [BW-1:0] q[$]);
    logic [BW-1:0] e;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: unexpected beat %0h, expected none", name, act);
    end else begin
      e = q.pop_front();
      check(name, act, e);
    end
  endtask

  // One clock: sample handshakes before the edge, update scoreboards, return #1 after the edge.
  task automatic step();
    logic acc, drn, acc0, drn0;
    @(negedge clk);
    acc  = in_valid & in_ready;
    drn  = out_valid & out_ready;
    acc0 = in_valid0 & in_ready0;
    drn0 = out_valid0 & out_ready0;
    if (drn)  sb_take("skid1_out", {out_ctrl, out_data}, exp_q);
    if (drn0) sb_take("skid0_out", {out_ctrl0, out_data0}, exp0_q);
    if (flush) begin
      exp_q.delete();
      exp0_q.delete();
    end else begin
      if (acc)  exp_q.push_back({in_ctrl, in_data});
      if (acc0) exp0_q.push_back({in_ctrl0, in_data0});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_ctrl   = c;
    in_data   = d;
  endtask

  typedef struct {
    logic              iv;
    logic              ordy;
    logic              fl;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [1:0]        exp_occ;
    logic              exp_rdy;
    logic              exp_ov;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [BW-1:0] head;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    in_valid0 = 1'b0; out_ready0 = 1'b0; in_ctrl0 = '0; in_data0 = '0;

    // Backpressure, flush collisions, flush with drain.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 11'h00A, DATA_W'(8'h0A), 2'd1, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 11'h00B, DATA_W'(8'h0B), 2'd2, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 11'h00C, DATA_W'(8'h0C), 2'd2, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 11'h00C, DATA_W'(8'h0C), 2'd2, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 11'h00C, DATA_W'(8'h0C), 2'd1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 11'h00C, DATA_W'(8'h0C), 2'd1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 11'h000, DATA_W'(8'h00), 2'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 11'h311, DATA_W'(8'h11), 2'd1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 11'h322, DATA_W'(8'h22), 2'd2, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 11'h355, DATA_W'(8'h55), 2'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 11'h333, DATA_W'(8'h33), 2'd1, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 11'h355, DATA_W'(8'h55), 2'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 11'h000, DATA_W'(8'h00), 2'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 11'h444, DATA_W'(8'h44), 2'd1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 11'h000, DATA_W'(8'h00), 2'd0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", BW'(out_valid), BW'(0));
    check("rst_out_ctrl", BW'(out_ctrl), BW'(0));
    check("rst_out_data", BW'(out_data), BW'(0));
    check("rst_occupancy", BW'(occupancy), BW'(0));
    reset = 1'b0;
    check("rst_in_ready", BW'(in_ready), BW'(1));

    // ---------------- table vectors ----------------
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ctrl, vecs[i].data);
      step();
      check($sformatf("vec%0d_occ", i), BW'(occupancy), BW'(vecs[i].exp_occ));
      check($sformatf("vec%0d_in_ready", i), BW'(in_ready), BW'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_out_valid", i), BW'(out_valid), BW'(vecs[i].exp_ov));
      head = (exp_q.size() != 0) ? exp_q[0] : '0;
      check($sformatf("vec%0d_out_ctrl", i), BW'(out_ctrl),
            vecs[i].exp_ov ? BW'(head[BW-1:DATA_W]) : BW'(0));
    end
    check("flush_stale_data", BW'(out_data), BW'(8'h44));

    // ---------------- streaming ----------------
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, CTRL_W'(i), DATA_W'(i));
      step();
      check($sformatf("stream%0d_valid", i), BW'(out_valid), BW'(1));
      check($sformatf("stream%0d_data", i), BW'(out_data), BW'(i));
      check($sformatf("stream%0d_in_ready", i), BW'(in_ready), BW'(1));
    end
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    step();
    check("stream_drained", BW'(occupancy), BW'(0));

    // ---------------- SKID=0 pass-through ----------------
    in_valid0 = 1'b1; out_ready0 = 1'b0; in_ctrl0 = 11'h107; in_data0 = DATA_W'(8'h07);
    step();
    in_ctrl0 = 11'h108; in_data0 = DATA_W'(8'h08);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("s0_stall%0d_in_ready", i), BW'(in_ready0), BW'(0));
      check($sformatf("s0_stall%0d_data", i), BW'(out_data0), BW'(8'h07));
      check($sformatf("s0_stall%0d_occ", i), BW'(occupancy0), BW'(1));
      step();
    end
    out_ready0 = 1'b1;
    #1;
    check("s0_comb_in_ready", BW'(in_ready0), BW'(1));
    step();
    check("s0_next_valid", BW'(out_valid0), BW'(1));
    check("s0_next_data", BW'(out_data0), BW'(8'h08));
    in_valid0 = 1'b0;
    step();
    check("s0_empty_valid", BW'(out_valid0), BW'(0));
    check("s0_empty_ctrl", BW'(out_ctrl0), BW'(0));
    check("s0_empty_occ", BW'(occupancy0), BW'(0));
    out_ready0 = 1'b0;

    // ---------------- reset mid-stream ----------------
    drive(1'b1, 1'b0, 1'b0, 11'h061, DATA_W'(8'h61));
    step();
    drive(1'b1, 1'b0, 1'b0, 11'h062, DATA_W'(8'h62));
    step();
    check("pre_rst_occ", BW'(occupancy), BW'(2));
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_valid", BW'(out_valid), BW'(0));
    check("async_rst_ctrl", BW'(out_ctrl), BW'(0));
    check("async_rst_occ", BW'(occupancy), BW'(0));
    exp_q.delete();
    exp0_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("post_rst_in_ready", BW'(in_ready), BW'(1));
    check("post_rst_valid", BW'(out_valid), BW'(0));

`ifdef PIPE_STAGE_STATS_EN
    // ---------------- statistics ----------------
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("stats_rst_stall", BW'(stall_cnt), BW'(0));
    check("stats_rst_bubble", BW'(bubble_cnt), BW'(0));
    step();
    step();
    drive(1'b1, 1'b0, 1'b0, 11'h0EE, DATA_W'(8'hEE));
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (5) step();
    check("stats_stall5", BW'(stall_cnt), BW'(5));
    check("stats_bubble3", BW'(bubble_cnt), BW'(3));
    repeat (65534) @(posedge clk);
    #1;
    check("stats_stall_sat", BW'(stall_cnt), BW'(16'hFFFF));
    check("stats_bubble_hold", BW'(bubble_cnt), BW'(3));
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
`endif

    check("sb_empty", BW'(exp_q.size()), BW'(0));
    check("sb0_empty", BW'(exp0_q.size()), BW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
